// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings and default widths for the MIPS MEM-stage
// data memory and its load extender.
//   MEM_WR_*  : store width select (i_mem_wr_src); 2'b11 behaves as SW
//   MEM_RD_*  : load format select (i_mem_rd_src); 3'b101..3'b111 behave as LW
package mips_mem_pkg;

  localparam int IO_BUS_SIZE_DEF   = 32;
  localparam int MEM_ADDR_SIZE_DEF = 5;

  typedef enum logic [1:0] {
    MEM_WR_SW = 2'b00,
    MEM_WR_SH = 2'b01,
    MEM_WR_SB = 2'b10
  } mem_wr_e;

  typedef enum logic [2:0] {
    MEM_RD_LW  = 3'b000,
    MEM_RD_LH  = 3'b001,
    MEM_RD_LHU = 3'b010,
    MEM_RD_LB  = 3'b011,
    MEM_RD_LBU = 3'b100
  } mem_rd_e;

endpackage

// File: rtl/mips_mem_ld_ext.sv
// mips_mem_ld_ext: purely combinational load formatter. Takes a full memory
// word and a load format select and produces the sign/zero extended result.
// Ports:
//   i_word     in  IO_BUS_SIZE  raw word read from memory
//   i_rd_src   in  3            load format (MEM_RD_*)
//   o_mem_rd   out IO_BUS_SIZE  formatted load data
module mips_mem_ld_ext
  import mips_mem_pkg::*;
#(
  parameter int IO_BUS_SIZE = IO_BUS_SIZE_DEF
) (
  input  logic [IO_BUS_SIZE-1:0] i_word,
  input  logic [2:0]             i_rd_src,
  output logic [IO_BUS_SIZE-1:0] o_mem_rd
);

  // Fill the whole word with the extension bit first, then overlay the low
  // lanes; this stays legal even when IO_BUS_SIZE is exactly 16.
  always_comb begin
    o_mem_rd = i_word;
    case (i_rd_src)
      MEM_RD_LH: begin
        o_mem_rd       = {IO_BUS_SIZE{i_word[15]}};
        o_mem_rd[15:0] = i_word[15:0];
      end
      MEM_RD_LHU: begin
        o_mem_rd       = '0;
        o_mem_rd[15:0] = i_word[15:0];
      end
      MEM_RD_LB: begin
        o_mem_rd      = {IO_BUS_SIZE{i_word[7]}};
        o_mem_rd[7:0] = i_word[7:0];
      end
      MEM_RD_LBU: begin
        o_mem_rd      = '0;
        o_mem_rd[7:0] = i_word[7:0];
      end
      default: o_mem_rd = i_word;
    endcase
  end

endmodule

// File: rtl/mips_mem.sv
// mips_mem: MEM-stage data memory. Word-addressed array with synchronous
// writes (SW/SH/SB merged into the old word) and combinational formatted
// reads (LW/LH/LHU/LB/LBU). Reset and flush both clear the array; either one
// discards a write in the same cycle.
// Optional: define MIPS_MEM_DEBUG_BUS_EN to drive o_bus_debug with the array
// image; otherwise o_bus_debug is tied to zero.
// Ports:
//   i_clk         in  1         clock, rising edge
//   i_reset       in  1         synchronous active-high reset
//   i_flush       in  1         synchronous active-high array clear
//   i_mem_wr_rd   in  1         1 = write this cycle
//   i_mem_wr_src  in  2         store width (MEM_WR_*)
//   i_mem_rd_src  in  3         load format (MEM_RD_*)
//   i_mem_addr    in  MEM_ADDR_SIZE  word address
//   i_bus_b       in  IO_BUS_SIZE    store data
//   o_mem_rd      out IO_BUS_SIZE    formatted load data
//   o_bus_debug   out DEPTH*IO_BUS_SIZE  word i at [i*IO_BUS_SIZE +: IO_BUS_SIZE]
module mips_mem
  import mips_mem_pkg::*;
#(
  parameter int IO_BUS_SIZE   = IO_BUS_SIZE_DEF,
  parameter int MEM_ADDR_SIZE = MEM_ADDR_SIZE_DEF
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_flush,
  input  logic                                     i_mem_wr_rd,
  input  logic [1:0]                               i_mem_wr_src,
  input  logic [2:0]                               i_mem_rd_src,
  input  logic [MEM_ADDR_SIZE-1:0]                 i_mem_addr,
  input  logic [IO_BUS_SIZE-1:0]                   i_bus_b,
  output logic [IO_BUS_SIZE-1:0]                   o_mem_rd,
  output logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] o_bus_debug
);

  localparam int DEPTH = 2**MEM_ADDR_SIZE;

  logic [IO_BUS_SIZE-1:0] mem [DEPTH];
  logic [IO_BUS_SIZE-1:0] rd_word;
  logic [IO_BUS_SIZE-1:0] wr_word;

  assign rd_word = mem[i_mem_addr];

  // Sub-word stores keep the untouched upper bits of the addressed word.
  always_comb begin
    wr_word = rd_word;
    case (i_mem_wr_src)
      MEM_WR_SH: wr_word[15:0] = i_bus_b[15:0];
      MEM_WR_SB: wr_word[7:0]  = i_bus_b[7:0];
      default:   wr_word       = i_bus_b;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_mem_wr_rd) begin
      mem[i_mem_addr] <= wr_word;
    end
  end

  mips_mem_ld_ext #(
    .IO_BUS_SIZE (IO_BUS_SIZE)
  ) u_ld_ext (
    .i_word   (rd_word),
    .i_rd_src (i_mem_rd_src),
    .o_mem_rd (o_mem_rd)
  );

`ifdef MIPS_MEM_DEBUG_BUS_EN
  always_comb begin
    o_bus_debug = '0;
    for (int i = 0; i < DEPTH; i++) o_bus_debug[i*IO_BUS_SIZE +: IO_BUS_SIZE] = mem[i];
  end
`else
  assign o_bus_debug = '0;
`endif

endmodule

// File: tb/tb_mips_mem.sv
module tb_mips_mem;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_flush;
  logic          i_mem_wr_rd;
  logic [1:0]    i_mem_wr_src;
  logic [2:0]    i_mem_rd_src;
  logic [4:0]    i_mem_addr;
  logic [31:0]   i_bus_b;
  logic [31:0]   o_mem_rd;
  logic [1023:0] o_bus_debug;

  int tests = 0;
  int fails = 0;
  logic [31:0] fill_val [20];

  always #5 i_clk = ~i_clk;

  mips_mem u_dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_mem_wr_rd  (i_mem_wr_rd),
    .i_mem_wr_src (i_mem_wr_src),
    .i_mem_rd_src (i_mem_rd_src),
    .i_mem_addr   (i_mem_addr),
    .i_bus_b      (i_bus_b),
    .o_mem_rd     (o_mem_rd),
    .o_bus_debug  (o_bus_debug)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational read, sampled between clock edges with no write pending.
  task automatic rd(input logic [4:0] addr, input logic [2:0] src, output logic [31:0] data);
    i_mem_wr_rd  = 1'b0;
    i_mem_addr   = addr;
    i_mem_rd_src = src;
    #1;
    data = o_mem_rd;
  endtask

  task automatic check_rd(input string tag, input logic [4:0] addr, input logic [2:0] src,
                          input logic [31:0] exp);
    logic [31:0] d;
    rd(addr, src, d);
    check(tag, d, exp);
  endtask

  // Debug slice expectation depends on whether the debug bus is built in.
  task automatic check_dbg(input string tag, input int idx, input logic [31:0] word);
`ifdef MIPS_MEM_DEBUG_BUS_EN
    check(tag, o_bus_debug[idx*32 +: 32], word);
`else
    check(tag, o_bus_debug[idx*32 +: 32], 32'h0);
`endif
  endtask

  task automatic wr(input logic [4:0] addr, input logic [1:0] src, input logic [31:0] data);
    @(negedge i_clk);
    i_mem_wr_rd  = 1'b1;
    i_mem_wr_src = src;
    i_mem_addr   = addr;
    i_bus_b      = data;
    @(negedge i_clk);
    i_mem_wr_rd  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      check_rd(tag, 5'(a), 3'b000, 32'h0);
      check_dbg(tag, a, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] d;
    i_reset = 1'b1; i_flush = 1'b0; i_mem_wr_rd = 1'b0;
    i_mem_wr_src = 2'b00; i_mem_rd_src = 3'b000; i_mem_addr = '0; i_bus_b = '0;

    // Reset held 3 cycles, then all addresses/formats read 0
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      check_rd("reset_lw",  5'(a), 3'b000, 32'h0);
      check_rd("reset_lh",  5'(a), 3'b001, 32'h0);
      check_rd("reset_lhu", 5'(a), 3'b010, 32'h0);
      check_rd("reset_lb",  5'(a), 3'b011, 32'h0);
      check_rd("reset_lbu", 5'(a), 3'b100, 32'h0);
    end
    check("reset_dbg_low",  o_bus_debug[511:480], 32'h0);
    check("reset_dbg_high", o_bus_debug[1023:992], 32'h0);

    // SW to addr 3; not visible before the edge, visible after
    @(negedge i_clk);
    i_mem_wr_rd = 1'b1; i_mem_wr_src = 2'b00; i_mem_addr = 5'd3;
    i_bus_b = 32'hDEADBEEF; i_mem_rd_src = 3'b000;
    #1 check("sw_not_early", o_mem_rd, 32'h0);
    @(negedge i_clk);
    i_mem_wr_rd = 1'b0;
    check_rd("sw_lw3", 5'd3, 3'b000, 32'hDEADBEEF);
    check_dbg("sw_dbg3", 3, 32'hDEADBEEF);
    check_rd("sw_neighbour4", 5'd4, 3'b000, 32'h0);

    // Sub-word merge at addr 5
    wr(5'd5, 2'b00, 32'h11223344);
    wr(5'd5, 2'b10, 32'h000000AA);
    check_rd("sb_merge", 5'd5, 3'b000, 32'h112233AA);
    wr(5'd5, 2'b01, 32'h0000BEEF);
    check_rd("sh_merge", 5'd5, 3'b000, 32'h1122BEEF);
    check_dbg("sh_dbg5", 5, 32'h1122BEEF);

    // Load extension on 0x0000F08F
    wr(5'd7, 2'b00, 32'h0000F08F);
    check_rd("ld_lw",  5'd7, 3'b000, 32'h0000F08F);
    check_rd("ld_lh",  5'd7, 3'b001, 32'hFFFFF08F);
    check_rd("ld_lhu", 5'd7, 3'b010, 32'h0000F08F);
    check_rd("ld_lb",  5'd7, 3'b011, 32'hFFFFFF8F);
    check_rd("ld_lbu", 5'd7, 3'b100, 32'h0000008F);
    check_rd("ld_101", 5'd7, 3'b101, 32'h0000F08F);
    check_rd("ld_110", 5'd7, 3'b110, 32'h0000F08F);
    check_rd("ld_111", 5'd7, 3'b111, 32'h0000F08F);

    // Positive sign bits, and wr_src=11 acting as SW over old contents
    wr(5'd8, 2'b00, 32'hA5A57F7F);
    check_rd("pos_lh", 5'd8, 3'b001, 32'h00007F7F);
    check_rd("pos_lb", 5'd8, 3'b011, 32'h0000007F);
    wr(5'd8, 2'b11, 32'h80018002);
    check_rd("wr11_sw", 5'd8, 3'b000, 32'h80018002);
    check_rd("wr11_lb", 5'd8, 3'b011, 32'h00000002);
    check_rd("wr11_lh", 5'd8, 3'b001, 32'hFFFF8002);

    // Highest address
    wr(5'd31, 2'b00, 32'hCAFEF00D);
    check_rd("top_addr", 5'd31, 3'b000, 32'hCAFEF00D);
    check_dbg("top_dbg", 31, 32'hCAFEF00D);

    // wr_rd=0 for 5 cycles must not write
    @(negedge i_clk);
    i_mem_wr_rd = 1'b0; i_mem_addr = 5'd2; i_bus_b = 32'h12345678; i_mem_wr_src = 2'b00;
    repeat (5) @(negedge i_clk);
    check_rd("no_write", 5'd2, 3'b000, 32'h0);

    // Reset in the same cycle as a write discards it
    @(negedge i_clk);
    i_reset = 1'b1; i_mem_wr_rd = 1'b1; i_mem_wr_src = 2'b00;
    i_mem_addr = 5'd9; i_bus_b = 32'h55555555;
    @(negedge i_clk);
    i_reset = 1'b0; i_mem_wr_rd = 1'b0;
    check_rd("rst_wr_discard", 5'd9, 3'b000, 32'h0);
    check_rd("rst_clears3", 5'd3, 3'b000, 32'h0);

    // Fill 0..19, flush with simultaneous write
    for (int a = 0; a < 20; a++) begin
      fill_val[a] = $urandom | 32'h1;
      wr(5'(a), 2'b00, fill_val[a]);
    end
    check_rd("fill0",  5'd0,  3'b000, fill_val[0]);
    check_rd("fill19", 5'd19, 3'b000, fill_val[19]);
    check_dbg("fill_dbg10", 10, fill_val[10]);
    @(negedge i_clk);
    i_flush = 1'b1; i_mem_wr_rd = 1'b1; i_mem_wr_src = 2'b00;
    i_mem_addr = 5'd4; i_bus_b = 32'h0BADF00D;
    @(negedge i_clk);
    i_flush = 1'b0; i_mem_wr_rd = 1'b0;
    check_all_zero("flush_zero");

    // Refill, then reset and flush together with a write
    for (int a = 0; a < 20; a++) begin
      fill_val[a] = $urandom | 32'h1;
      wr(5'(a), 2'b00, fill_val[a]);
    end
    check_rd("refill12", 5'd12, 3'b000, fill_val[12]);
    @(negedge i_clk);
    i_reset = 1'b1; i_flush = 1'b1; i_mem_wr_rd = 1'b1;
    i_mem_addr = 5'd12; i_bus_b = 32'hFEEDFACE;
    @(negedge i_clk);
    i_reset = 1'b0; i_flush = 1'b0; i_mem_wr_rd = 1'b0;
    check_all_zero("rstflush_zero");

    // Writes work again after flush
    wr(5'd12, 2'b10, 32'hFFFFFF81);
    check_rd("post_flush_sb", 5'd12, 3'b000, 32'h00000081);
    rd(5'd12, 3'b011, d);
    check("post_flush_lb", d, 32'hFFFFFF81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_mem.md
Name: mips_mem

Overview:
- Data memory for the MEM stage of the 5-stage MIPS pipeline.
- Word-addressed register-file-style RAM with synchronous writes and combinational reads.
- Supports store widths SW/SH/SB and load formats LW/LH/LHU/LB/LBU.
- Exposes the full array contents on a flat debug bus for the debug unit.

Parameters:
- IO_BUS_SIZE, 32: data word width in bits; must be ≥16.
- MEM_ADDR_SIZE, 5: word address width; depth = 2**MEM_ADDR_SIZE words.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous, active-high clear of the whole array.
- i_mem_wr_rd  in  1  1 = write this cycle, 0 = read only.
- i_mem_wr_src  in  2  store width select.
- i_mem_rd_src  in  3  load format select.
- i_mem_addr  in  MEM_ADDR_SIZE  word address.
- i_bus_b  in  IO_BUS_SIZE  store data (rt value).
- o_mem_rd  out  IO_BUS_SIZE  formatted load data.
- o_bus_debug  out  2**MEM_ADDR_SIZE*IO_BUS_SIZE  flat image of the array; word i at bits [i*IO_BUS_SIZE +: IO_BUS_SIZE].

Behaviour:
- Storage: 2**MEM_ADDR_SIZE words of IO_BUS_SIZE bits.
- Update priority at each rising edge: i_reset > i_flush > write.
- Reset:
  - i_reset=1 clears every word to 0 at the edge.
  - After reset, o_mem_rd=0 for every address and format, and o_bus_debug=0.
  - Reset mid-write discards the write.
- Flush: same effect as reset (all words to 0), used for pipeline/debug restart. A write in the same cycle is discarded.
- Write: when i_mem_wr_rd=1 and neither reset nor flush is active, the addressed word is updated at the edge (1-cycle latency) according to i_mem_wr_src:
  - 00 SW: whole word = i_bus_b.
  - 01 SH: bits[15:0] = i_bus_b[15:0]; upper bits keep their old value.
  - 10 SB: bits[7:0] = i_bus_b[7:0]; upper bits keep their old value.
  - 11: treated as SW.
- Read:
  - Combinational from the current array contents; no read enable.
  - A write becomes visible on o_mem_rd in the cycle after its edge, never earlier.
- Load formats, selected by i_mem_rd_src from w = mem[i_mem_addr]:
  - 000 LW: w.
  - 001 LH: sign-extend w[15:0].
  - 010 LHU: zero-extend w[15:0].
  - 011 LB: sign-extend w[7:0].
  - 100 LBU: zero-extend w[7:0].
  - 101–111: treated as LW.
- Addressing: the address covers the full depth, so no out-of-range case exists. No byte offset; sub-word accesses always use the low lanes.
- o_bus_debug: combinational, always reflects the current array contents.

Optional Feature:
- Macro MIPS_MEM_DEBUG_BUS_EN.
- Defined: o_bus_debug carries the array image as described in Behaviour.
- Undefined: o_bus_debug is tied to all zeros; the port remains so the interface is unchanged. All other behaviour is identical.

Decomposition:
- Shared package mips_mem_pkg holds:
  - Store encodings MEM_WR_SW/SH/SB.
  - Load encodings MEM_RD_LW/LH/LHU/LB/LBU.
  - Default widths.
- One natural sub-module, mips_mem_ld_ext: purely combinational load extender (word + rd_src → o_mem_rd), reusable by other load paths.
- Write-merge logic stays in the top module.

Test Plan:
- Reset: hold i_reset=1 for 3 cycles, release → every address reads 0 in all five formats; o_bus_debug == 0.
- Word write/read: SW 0xDEADBEEF to addr 3 → next cycle LW at addr 3 = 0xDEADBEEF; o_bus_debug[3*32 +: 32] = 0xDEADBEEF.
- Sub-word merge: SW 0x11223344 to addr 5, then SB 0x000000AA → LW reads 0x112233AA. Then SH 0x0000BEEF → LW reads 0x1122BEEF.
- Load extension: mem[7]=0x0000F08F:
  - LH → 0xFFFFF08F
  - LHU → 0x0000F08F
  - LB → 0xFFFFFF8F
  - LBU → 0x0000008F
  - rd_src=111 → 0x0000F08F
- Write with i_mem_wr_rd=0: drive addr 2, data 0x12345678, wr_rd=0 for 5 cycles → mem[2] unchanged (0).
- Flush/priority: fill addrs 0–19 with random words; pulse i_flush with a simultaneous write → all words 0, write discarded. Repeat with i_reset and i_flush both high → all 0.
